// File: rtl/sm2201_isa_pkg.sv
// Shared types and constants for the Sm2201 ISA-side responder.
// Holds the FSM state enum and the IC82x6 transceiver direction codes.
package sm2201_isa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_SETTLE,
    WR_HOLD,
    RD_REQ,
    RD_HOLD
  } isa_state_t;

  localparam logic [9:0] DEFAULT_BASE_ADDR = 10'h300;
  localparam logic [7:0] FLOAT_BYTE = 8'hFF;

  localparam logic XCVR_DIR_READ = 1'b0;
  localparam logic XCVR_DIR_WRITE = 1'b1;

endpackage

// File: rtl/isa_strobe_sync.sv
// Multi-flop synchronizer with edge detect for one async ISA line.
// Ports: clk, rst_n, async_in -> level (synced), fall, rise (1-clk pulses).
module isa_strobe_sync #(
  parameter int STAGES = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic fall,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {STAGES{RST_VAL}};
      last <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], async_in};
      last <= sync[STAGES-1];
    end
  end

  assign level = sync[STAGES-1];
  assign fall = last & ~level;
  assign rise = ~last & level;

endmodule

// File: rtl/isa_io_responder.sv
// ISA I/O slave for Sm2201: decodes port window, drives IC82x6 cs_n/dce.
// Ports: ISA bus in, IOCHRDY wait control, transceiver, CAMAC reg bus, errors.
module isa_io_responder
  import sm2201_isa_pkg::*;
#(
  parameter logic [9:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int ADDR_BITS = 3,
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE = 2,
  parameter int RD_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           isa_addr,
  input  logic                 isa_aen,
  input  logic                 isa_ior_n,
  input  logic                 isa_iow_n,
  output logic                 isa_iochrdy_oe,
  output logic                 xcvr_cs_n,
  output logic                 xcvr_dce,
  output logic [7:0]           xcvr_d_in,
  input  logic [7:0]           xcvr_d_out,
  output logic [ADDR_BITS-1:0] reg_addr,
  output logic                 reg_wr,
  output logic [7:0]           reg_wdata,
  output logic                 reg_rd,
  input  logic [7:0]           reg_rdata,
  input  logic                 reg_rvalid,
  output logic                 err_timeout,
  output logic                 err_short
);

  localparam int CNT_MAX =
    (SETTLE > RD_TIMEOUT) ? SETTLE : RD_TIMEOUT;
  localparam int CW = $clog2(CNT_MAX + 1);

  isa_state_t state, state_nxt;
  logic [CW-1:0] cnt;

  logic ior_lvl, ior_fall, ior_rise;
  logic iow_lvl, iow_fall, iow_rise;
  logic aen_lvl, aen_fall, aen_rise;
  logic match;

  logic wr_go, rd_go, rd_ok, rd_tmo, wr_short;
  logic unused_edges;

  isa_strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ior (
    .clk(clk), .rst_n(rst_n), .async_in(isa_ior_n),
    .level(ior_lvl), .fall(ior_fall), .rise(ior_rise)
  );

  isa_strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_iow (
    .clk(clk), .rst_n(rst_n), .async_in(isa_iow_n),
    .level(iow_lvl), .fall(iow_fall), .rise(iow_rise)
  );

  // aen resets high so nothing decodes until the bus is known idle
  isa_strobe_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_aen (
    .clk(clk), .rst_n(rst_n), .async_in(isa_aen),
    .level(aen_lvl), .fall(aen_fall), .rise(aen_rise)
  );

  // release is sensed by level so a missed edge cannot strand the FSM
  assign unused_edges = ^{ior_rise, iow_rise, aen_fall, aen_rise};

  assign match = !aen_lvl &&
    (isa_addr[9:ADDR_BITS] == BASE_ADDR[9:ADDR_BITS]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_go = 1'b0;
    rd_go = 1'b0;
    rd_ok = 1'b0;
    rd_tmo = 1'b0;
    wr_short = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          match && iow_fall && ior_lvl:
            state_nxt = WR_SETTLE;
          match && ior_fall && iow_lvl: begin
            state_nxt = RD_REQ;
            rd_go = 1'b1;
          end
          default: ;
        endcase
      end
      WR_SETTLE: begin
        if (iow_lvl) begin
          wr_short = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CW'(SETTLE - 1)) begin
          wr_go = 1'b1;
          state_nxt = WR_HOLD;
        end
      end
      WR_HOLD: if (iow_lvl) state_nxt = IDLE;
      RD_REQ: begin
        // early release wins so a late rvalid is dropped
        if (ior_lvl) begin
          state_nxt = IDLE;
        end else if (reg_rvalid) begin
          rd_ok = 1'b1;
          state_nxt = RD_HOLD;
        end else if (cnt == CW'(RD_TIMEOUT - 1)) begin
          rd_tmo = 1'b1;
          state_nxt = RD_HOLD;
        end
      end
      RD_HOLD: if (ior_lvl) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    xcvr_cs_n = (state == IDLE);
    xcvr_dce = XCVR_DIR_READ;
    if (state == WR_SETTLE || state == WR_HOLD)
      xcvr_dce = XCVR_DIR_WRITE;
    isa_iochrdy_oe = (state == RD_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      reg_addr <= '0;
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      reg_wdata <= 8'h00;
      xcvr_d_in <= FLOAT_BYTE;
      err_timeout <= 1'b0;
      err_short <= 1'b0;
    end else begin
      cnt <= (state_nxt != state) ? '0 : cnt + 1'b1;
      reg_wr <= wr_go;
      reg_rd <= rd_go;
      err_timeout <= rd_tmo;
      err_short <= wr_short;
      if (state == IDLE && state_nxt != IDLE)
        reg_addr <= isa_addr[ADDR_BITS-1:0];
      if (wr_go) reg_wdata <= xcvr_d_out;
      if (rd_ok) xcvr_d_in <= reg_rdata;
      else if (rd_tmo) xcvr_d_in <= FLOAT_BYTE;
    end
  end

endmodule

// File: tb/tb_isa_io_responder.sv
// Scoreboard bench for isa_io_responder: drivers push expected events,
// a negedge monitor pops and compares whenever the DUT emits one.
module tb_isa_io_responder;
  import sm2201_isa_pkg::*;

  localparam int SETTLE_T = 2;
  localparam int TMO_T = 15;

  localparam int EV_WR = 0;
  localparam int EV_RD = 1;
  localparam int EV_SHORT = 2;
  localparam int EV_TMO = 3;
  localparam int EV_RDATA = 4;

  typedef struct {
    int kind;
    logic [2:0] addr;
    logic [7:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [9:0] isa_addr;
  logic isa_aen, isa_ior_n, isa_iow_n;
  logic isa_iochrdy_oe, xcvr_cs_n, xcvr_dce;
  logic [7:0] xcvr_d_in, xcvr_d_out;
  logic [2:0] reg_addr;
  logic reg_wr, reg_rd, reg_rvalid;
  logic [7:0] reg_wdata, reg_rdata;
  logic err_timeout, err_short;

  ev_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic prev_oe = 1'b0;

  always #5 clk = ~clk;

  isa_io_responder dut (
    .clk(clk), .rst_n(rst_n),
    .isa_addr(isa_addr), .isa_aen(isa_aen),
    .isa_ior_n(isa_ior_n), .isa_iow_n(isa_iow_n),
    .isa_iochrdy_oe(isa_iochrdy_oe),
    .xcvr_cs_n(xcvr_cs_n), .xcvr_dce(xcvr_dce),
    .xcvr_d_in(xcvr_d_in), .xcvr_d_out(xcvr_d_out),
    .reg_addr(reg_addr), .reg_wr(reg_wr),
    .reg_wdata(reg_wdata), .reg_rd(reg_rd),
    .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid),
    .err_timeout(err_timeout), .err_short(err_short)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req);
    end
  endtask

  task automatic push(input int k, input logic [2:0] a,
                      input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic take(input int k, input logic [2:0] a,
                      input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event got=%0d want=none", k);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      chk("event_addr", {29'd0, a}, {29'd0, e.addr});
      if (k == EV_WR || k == EV_RDATA)
        chk("event_data", {24'd0, d}, {24'd0, e.data});
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_oe = 1'b0;
    end else begin
      if (reg_wr && reg_rd)
        chk("wr_rd_exclusive", 1, 0);
      if (reg_wr) take(EV_WR, reg_addr, reg_wdata);
      if (reg_rd) take(EV_RD, reg_addr, 8'h00);
      if (err_short) take(EV_SHORT, reg_addr, 8'h00);
      if (err_timeout) take(EV_TMO, reg_addr, 8'h00);
      if (prev_oe && !isa_iochrdy_oe)
        take(EV_RDATA, reg_addr, xcvr_d_in);
      prev_oe = isa_iochrdy_oe;
    end
  end

  // Reference: strobe low for n clocks covers the decode clock plus
  // SETTLE settle clocks only if n > SETTLE.
  task automatic do_write(input logic [9:0] a, input logic [7:0] d,
                          input int n);
    if (n > SETTLE_T) push(EV_WR, a[2:0], d);
    else push(EV_SHORT, a[2:0], 8'h00);
    @(negedge clk);
    isa_addr = a;
    isa_aen = 1'b0;
    xcvr_d_out = d;
    isa_iow_n = 1'b0;
    repeat (n) @(negedge clk);
    if (n > SETTLE_T) begin
      chk("wr_cs_low", xcvr_cs_n, 0);
      chk("wr_dce", xcvr_dce, 1);
    end
    isa_iow_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("wr_cs_release", xcvr_cs_n, 1);
    chk("wr_dce_release", xcvr_dce, 0);
  endtask

  // Reference: data returned if rvalid comes within RD_TIMEOUT clocks
  // counted from the reg_rd clock, otherwise the bus floats to FF.
  task automatic do_read(input logic [9:0] a, input int dly,
                         input logic [7:0] d);
    int n;
    push(EV_RD, a[2:0], 8'h00);
    if (dly < TMO_T) begin
      push(EV_RDATA, a[2:0], d);
    end else begin
      push(EV_TMO, a[2:0], 8'h00);
      push(EV_RDATA, a[2:0], FLOAT_BYTE);
    end
    @(negedge clk);
    isa_addr = a;
    isa_aen = 1'b0;
    isa_ior_n = 1'b0;
    n = 0;
    while (!reg_rd && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("rd_req_seen", reg_rd, 1);
    chk("rd_wait_state", isa_iochrdy_oe, 1);
    if (dly < TMO_T) begin
      repeat (dly) @(negedge clk);
      reg_rdata = d;
      reg_rvalid = 1'b1;
      @(negedge clk);
      reg_rvalid = 1'b0;
      reg_rdata = $urandom;
    end
    n = 0;
    while (isa_iochrdy_oe && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rd_wait_released", isa_iochrdy_oe, 0);
    @(negedge clk);
    chk("rd_cs_low", xcvr_cs_n, 0);
    chk("rd_dce", xcvr_dce, 0);
    isa_ior_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rd_cs_release", xcvr_cs_n, 1);
  endtask

  task automatic do_ignored(input logic [9:0] a, input logic aen,
                            input logic rd, input logic wr);
    logic seen_cs;
    seen_cs = 1'b0;
    @(negedge clk);
    isa_addr = a;
    isa_aen = aen;
    isa_ior_n = ~rd;
    isa_iow_n = ~wr;
    repeat (10) begin
      @(negedge clk);
      if (!xcvr_cs_n) seen_cs = 1'b1;
    end
    isa_ior_n = 1'b1;
    isa_iow_n = 1'b1;
    repeat (4) @(negedge clk);
    isa_aen = 1'b0;
    repeat (3) @(negedge clk);
    chk("ignored_cs_stays_high", seen_cs, 0);
  endtask

  task automatic reset_mid_read();
    int n;
    push(EV_RD, 3'd0, 8'h00);
    @(negedge clk);
    isa_addr = 10'h300;
    isa_aen = 1'b0;
    isa_ior_n = 1'b0;
    n = 0;
    while (!reg_rd && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk("rst_rd_req_seen", reg_rd, 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_oe", isa_iochrdy_oe, 0);
    chk("rst_async_cs", xcvr_cs_n, 1);
    chk("rst_async_d_in", xcvr_d_in, 8'hFF);
    @(negedge clk);
    isa_ior_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    isa_addr = 10'h000;
    isa_aen = 1'b1;
    isa_ior_n = 1'b1;
    isa_iow_n = 1'b1;
    xcvr_d_out = 8'h00;
    reg_rdata = 8'h00;
    reg_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_oe", isa_iochrdy_oe, 0);
    chk("rst_cs", xcvr_cs_n, 1);
    chk("rst_dce", xcvr_dce, 0);
    chk("rst_d_in", xcvr_d_in, 8'hFF);
    chk("rst_addr", reg_addr, 0);
    chk("rst_wr", reg_wr, 0);
    chk("rst_wdata", reg_wdata, 0);
    chk("rst_rd", reg_rd, 0);
    chk("rst_errs", {err_timeout, err_short}, 0);
    rst_n = 1'b1;
    isa_aen = 1'b0;
    repeat (4) @(negedge clk);

    do_write(10'h302, 8'hA5, 20);
    do_read(10'h305, 4, 8'h3C);
    chk("d_in_held", xcvr_d_in, 8'h3C);
    do_read(10'h300, 30, 8'h00);
    do_read(10'h307, 0, 8'h5A);
    do_read(10'h301, TMO_T - 1, 8'hC3);
    do_ignored(10'h310, 1'b0, 1'b0, 1'b1);
    do_ignored(10'h301, 1'b1, 1'b0, 1'b1);
    do_ignored(10'h301, 1'b0, 1'b1, 1'b1);
    do_write(10'h301, 8'h77, 1);
    do_write(10'h304, 8'h12, SETTLE_T);
    do_write(10'h306, 8'h34, SETTLE_T + 1);
    reset_mid_read();
    do_write(10'h303, 8'h96, 10);

    for (int i = 0; i < 40; i++) begin
      logic [9:0] a;
      a = 10'h300 | 10'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0)
        do_write(a, 8'($urandom), $urandom_range(1, 20));
      else
        do_read(a, $urandom_range(0, 18), 8'($urandom));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
